// File: rtl/kt_pkg.sv
// Shared types and constants for the multi-digit kitchen timer.
// Time is held as a chain of BCD digits; the state encoding is fixed here.
package kt_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } kt_state_t;

  localparam logic [3:0] DIG_MAX_UNITS    = 4'd9;
  localparam logic [3:0] DIG_MAX_SEC_TENS = 4'd5;

  // Bits needed to count 0..tick_div-1 (at least one bit).
  function automatic int presc_width(input int tick_div);
    return (tick_div <= 2) ? 1 : $clog2(tick_div);
  endfunction

endpackage

// File: rtl/m_bcd_digit.sv
// One BCD digit with modulus MAXV+1, chained to its neighbours by carry
// (increment) and borrow (decrement) signals.
module m_bcd_digit #(
  parameter logic [3:0] MAXV = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  input  logic       dec,
  input  logic       cin,
  input  logic       bin,
  output logic [3:0] digit,
  output logic       cout,
  output logic       bout
);

  logic [3:0] digit_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit_reg <= 4'd0;
    end else if (load) begin
      digit_reg <= load_val;
    end else if (inc && cin) begin
      digit_reg <= (digit_reg == MAXV) ? 4'd0 : digit_reg + 4'd1;
    end else if (dec && bin) begin
      digit_reg <= (digit_reg == 4'd0) ? MAXV : digit_reg - 4'd1;
    end
  end

  // A digit passes the carry/borrow on only when it is itself wrapping.
  assign cout  = cin && (digit_reg == MAXV);
  assign bout  = bin && (digit_reg == 4'd0);
  assign digit = digit_reg;

endmodule

// File: rtl/m_kitchen_timer_multi.sv
// BCD MM:SS countdown timer with pause/resume, preset reload after the
// alarm and a bounded alarm length. Single clock, internal 1 s tick enable.
module m_kitchen_timer_multi
  import kt_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int MIN_DIGITS = 2,
  parameter int ALARM_SEC  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    min_inc,
  input  logic                    sec_inc,
  output logic [4*MIN_DIGITS-1:0] min,
  output logic [7:0]              sec,
  output logic                    running,
  output logic                    paused,
  output logic                    alarm
);

  // Digit 0 = sec units, 1 = sec tens, 2.. = minute digits (LSD first).
  localparam int ND = MIN_DIGITS + 2;
  localparam int TW = 4 * ND;
  localparam int PW = presc_width(TICK_DIV);
  localparam int AW = (ALARM_SEC < 2) ? 1 : $clog2(ALARM_SEC);

  kt_state_t       state_reg, state_next;
  logic [PW-1:0]   presc_reg;
  logic [AW-1:0]   acnt_reg;
  logic [TW-1:0]   preset_reg;
  logic            running_reg, paused_reg, alarm_reg;

  logic [TW-1:0]   time_bus;
  logic [ND-1:0]   carry, borrow;
  logic            tick, acnt_last, time_nz, time_one;
  logic            dec_en, load_en, sec_inc_en, min_inc_en, capture;
  logic            presc_clr, presc_run, acnt_clr, acnt_inc;
  logic            unused_chain;

  assign tick      = (presc_reg == PW'(TICK_DIV - 1));
  assign acnt_last = (acnt_reg == AW'(ALARM_SEC - 1));
  assign time_nz   = |time_bus;
  assign time_one  = (time_bus == TW'(1));

  always_comb begin
    state_next = state_reg;
    dec_en     = 1'b0;
    load_en    = 1'b0;
    sec_inc_en = 1'b0;
    min_inc_en = 1'b0;
    capture    = 1'b0;
    presc_clr  = 1'b0;
    presc_run  = 1'b0;
    acnt_clr   = 1'b0;
    acnt_inc   = 1'b0;
    if (clear) begin
      state_next = ST_SET;
      presc_clr  = 1'b1;
    end else begin
      unique case (state_reg)
        ST_SET: begin
          if (start_stop) begin
            if (time_nz) begin
              capture    = 1'b1;
              presc_clr  = 1'b1;
              state_next = ST_RUN;
            end
          end else begin
            sec_inc_en = sec_inc;
            min_inc_en = min_inc;
          end
        end
        ST_RUN: begin
          if (start_stop) begin
            state_next = ST_PAUSE;
          end else begin
            presc_run = 1'b1;
            if (tick) begin
              dec_en = 1'b1;
              if (time_one) begin
                state_next = ST_ALARM;
                acnt_clr   = 1'b1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (start_stop) state_next = ST_RUN;
        end
        ST_ALARM: begin
          presc_run = 1'b1;
          if (start_stop || (tick && acnt_last)) begin
            load_en    = 1'b1;
            state_next = ST_SET;
          end else if (tick) begin
            acnt_inc = 1'b1;
          end
        end
        default: state_next = ST_SET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_SET;
      presc_reg   <= '0;
      acnt_reg    <= '0;
      preset_reg  <= '0;
      running_reg <= 1'b0;
      paused_reg  <= 1'b0;
      alarm_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (presc_clr)      presc_reg <= '0;
      else if (presc_run) presc_reg <= tick ? '0 : presc_reg + PW'(1);
      if (acnt_clr)       acnt_reg <= '0;
      else if (acnt_inc)  acnt_reg <= acnt_reg + AW'(1);
      if (capture)        preset_reg <= time_bus;
      running_reg <= (state_next == ST_RUN);
      paused_reg  <= (state_next == ST_PAUSE);
      alarm_reg   <= (state_next == ST_ALARM);
    end
  end

  // Increment chains restart at sec units and at the minute LSD so seconds
  // never carry into minutes; the decrement chain runs through all digits.
  genvar gi;
  for (gi = 0; gi < ND; gi++) begin : g_digit
    localparam logic [3:0] MAXV = (gi == 1) ? DIG_MAX_SEC_TENS : DIG_MAX_UNITS;
    logic cin_d, bin_d, inc_d;

    if (gi == 0 || gi == 2) begin : g_inc_head
      assign cin_d = 1'b1;
    end else begin : g_inc_link
      assign cin_d = carry[gi-1];
    end

    if (gi == 0) begin : g_dec_head
      assign bin_d = 1'b1;
    end else begin : g_dec_link
      assign bin_d = borrow[gi-1];
    end

    assign inc_d = (gi < 2) ? sec_inc_en : min_inc_en;

    m_bcd_digit #(.MAXV(MAXV)) u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (clear),
      .load     (load_en),
      .load_val (preset_reg[4*gi +: 4]),
      .inc      (inc_d),
      .dec      (dec_en),
      .cin      (cin_d),
      .bin      (bin_d),
      .digit    (time_bus[4*gi +: 4]),
      .cout     (carry[gi]),
      .bout     (borrow[gi])
    );
  end

  assign unused_chain = &{1'b0, carry[1], carry[ND-1], borrow[ND-1]};

  assign min     = time_bus[TW-1:8];
  assign sec     = time_bus[7:0];
  assign running = running_reg;
  assign paused  = paused_reg;
  assign alarm   = alarm_reg;

endmodule

// File: doc/m_kitchen_timer_multi.md
Name: m_kitchen_timer_multi

Overview:
- Parametrised successor of the board kitchen timer: BCD MM:SS countdown with a configurable number of minute digits.
- Fully synchronous: one system clock, an internal 1 s tick enable, no derived or gated clocks.
- Adds pause/resume, a preset reload after the alarm, and a bounded-length alarm output.
- Sits between debounced button pulses and the 7-segment display driver.

Parameters:
- TICK_DIV, 50000000, clk cycles per countdown second (>=2).
- MIN_DIGITS, 2, BCD minute digits (1..4); the minute field spans 0..10^MIN_DIGITS-1.
- ALARM_SEC, 10, seconds the alarm stays asserted before auto-reload (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_stop  in  1  single-cycle pulse; starts, pauses or resumes the timer, or silences the alarm.
- clear  in  1  single-cycle pulse; abort and zero.
- min_inc  in  1  single-cycle pulse; increments minutes, honoured in SET only.
- sec_inc  in  1  single-cycle pulse; increments seconds, honoured in SET only.
- min  out  4*MIN_DIGITS  BCD minutes; the most significant digit is the leftmost nibble.
- sec  out  8  BCD seconds, 00..59.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- alarm  out  1  high in ALARM.

Behaviour:
- Reset (rst=1 at a clk edge): state=SET; min=0, sec=0; preset=0; prescaler=0; alarm counter=0; running, paused and alarm all 0.
- States: SET, RUN, PAUSE, ALARM.
  - Encoding is defined in the shared package.
  - Outputs are registered; every transition and output update is visible 1 cycle after the input pulse.
- Input priority, highest first: rst > clear > start_stop > min_inc/sec_inc > tick.
- clear, in any state: go to SET; min=0, sec=0; preset is unchanged.
- SET:
  - sec_inc: sec+1, wrapping 59->00 with no carry into min.
  - min_inc: min+1, wrapping max->0.
  - If both arrive in the same cycle, both are applied.
  - start_stop with time != 0: capture preset <= {min,sec}, prescaler <= 0, go to RUN.
  - start_stop with time == 0: ignored.
- RUN:
  - The prescaler counts 0..TICK_DIV-1; tick is asserted when prescaler==TICK_DIV-1.
  - The first tick therefore falls TICK_DIV cycles after entry from SET.
  - On tick, decrement time:
    - sec units digit borrows 0->9;
    - sec tens digit borrows 0->5;
    - minute digits borrow 0->9.
  - If the decrement yields 00:00, go to ALARM in the same update (alarm=1 next cycle) and clear the alarm counter.
  - start_stop: go to PAUSE; the prescaler holds its value; a coincident tick is dropped (no decrement).
  - min_inc/sec_inc are ignored.
- PAUSE:
  - Time and prescaler are frozen.
  - start_stop: return to RUN and resume from the held prescaler value.
- ALARM:
  - Time reads 00:00; the prescaler keeps running.
  - The alarm counter increments on each tick.
  - When the counter reaches ALARM_SEC, or on start_stop (whichever comes first): reload {min,sec} <= preset and go to SET.
  - clear in ALARM: go to SET with 00:00, per the priority above.
- Arithmetic:
  - All time arithmetic is per-digit BCD; no binary intermediate.
  - A digit never holds a value above 9 (above 5 for the sec tens digit).
- Reset mid-operation: rst wins over every input and returns the block to the full reset state.

Decomposition:
- Package kt_pkg holds:
  - state typedef (SET=0, RUN=1, PAUSE=2, ALARM=3);
  - BCD constants (DIG_MAX_UNITS=9, DIG_MAX_SEC_TENS=5);
  - a helper function returning the prescaler width from TICK_DIV.
- Sub-module m_bcd_digit, one per digit, chained via carry/borrow.
  - Parameter: MAXV (the digit's modulus-1).
  - Inputs: clk, rst, clr (synchronous zero), load with value, inc, dec, cin/bin.
  - Outputs: digit[3:0], cout/bout.
- The top level holds the FSM, prescaler, alarm counter, preset register and the digit chain.

Test Plan (TICK_DIV=4, MIN_DIGITS=2, ALARM_SEC=3):
- Reset, then 1 min_inc + 2 sec_inc -> min=0x01, sec=0x02, running=0; 60 sec_inc from 00 -> sec wraps to 0x00 with min unchanged.
- Set 01:02, start_stop -> running=1 next cycle; after 4 cycles 01:01; after 12 cycles 00:59; after 248 cycles total 00:00 with alarm=1.
- Start from 00:05, pulse start_stop at cycle 6 -> paused=1 and time 00:04 frozen for 50 cycles; start_stop -> time reaches 00:03 two cycles later (held prescaler=2).
- Alarm with no input -> alarm deasserts after 3 ticks (12 cycles); state=SET; time reloads preset 00:05; a second start re-runs from 00:05.
- clear and start_stop in the same cycle during RUN at 00:03 -> state SET, time 00:00, running=0; start_stop with 00:00 -> stays SET.
- min_inc with min=0x99 -> 0x00; MIN_DIGITS=3 build: 999 -> 000; rst asserted in ALARM -> all outputs 0 the next cycle.
